fifo_stream_drain: RTL and testbench
====================================

# fifo_stream_drain

Read-side drain stage directly downstream of the team's synchronous FIFO. It issues FIFO reads, absorbs the FIFO's one-cycle registered read latency in a 3-entry output buffer, and presents words on a valid/ready stream. There is no combinational path from `m_ready` to `fifo_rd_en`. Steady-state throughput is one word per clock.

## Interface
- `DATA_W`, 8: FIFO word and stream data width.
- `CNT_W`, 16: width of the transfer counter.
- `clk`  input  1  clock; all logic on the rising edge.
- `rst_n`  input  1  synchronous reset, active-low.
- `drain_en`  input  1  when high, new FIFO reads are allowed; when low, the buffer still empties.
- `fifo_empty`  input  1  FIFO empty flag.
- `fifo_data_out`  input  DATA_W  FIFO read data, valid the cycle after an accepted read.
- `fifo_rd_en`  output  1  FIFO read strobe.
- `m_valid`  output  1  stream word available.
- `m_ready`  input  1  consumer accepts.
- `m_data`  output  DATA_W  stream word.
- `buf_occ`  output  2  buffered word count, 0..3.
- `xfer_cnt`  output  CNT_W  completed stream transfers, wraps modulo 2^CNT_W.

## Operation
- **State**
  - 3-entry circular buffer with `wr_ptr` and `rd_ptr`, each counting 0,1,2,0.
  - `occ`: 0..3.
  - `inflight`: 1 bit, meaning a read was issued last cycle.
  - `xfer_cnt`.
- **Read issue (combinational):** `fifo_rd_en = rst_n && drain_en && !fifo_empty && (occ + inflight < 3)`.
  - The condition guarantees a free slot for every read in flight, even if `m_ready` stays low.
  - `fifo_rd_en` never depends on `m_ready`.
  - `fifo_rd_en` is never asserted while `fifo_empty` is high.
- **Inflight:** `inflight <= fifo_rd_en` each clock.
- **Capture:** when `inflight` is high, `fifo_data_out` is written at `wr_ptr`, then `wr_ptr` advances.
- **Stream output:**
  - `m_valid = (occ != 0)`.
  - `m_data = buf[rd_ptr]`.
  - Pop on `m_valid && m_ready`: `rd_ptr` advances and `xfer_cnt` increments.
- **Simultaneous capture and pop:**
  - `occ` is unchanged and both pointers advance.
  - This holds at `occ == 3` as well, because capture only occurs when a slot was reserved.
- **`m_valid`/`m_data` stability:** once `m_valid` is high, `m_valid` and `m_data` hold until the word is accepted.
- **`drain_en` low:** blocks new reads only. An inflight word is still captured, and buffered words are still emitted.
- **Reset (`rst_n` low at an edge):**
  - Clears `occ`, both pointers, `inflight` and `xfer_cnt`.
  - An inflight word is discarded; the FIFO is reset on the same reset.
  - Reset has priority over capture and pop in the same cycle.

## Timing
- **Reset values:**
  - `m_valid` = 0, `buf_occ` = 0, `xfer_cnt` = 0.
  - `fifo_rd_en` = 0 while `rst_n` is low.
  - `m_data` = 0: buffer contents are don't-care but are cleared to 0.
- **Latency:** `fifo_rd_en` is asserted in cycle N, `fifo_data_out` is valid in cycle N+1, and the word is captured at the end of N+1. `m_valid` rises in cycle N+2, so FIFO to stream is 2 cycles.
- **Throughput:** with `m_ready` held high and the FIFO non-empty:
  - Steady state is `occ = 1`, `inflight = 1`.
  - `fifo_rd_en` stays high every cycle.
  - One transfer per cycle after the 2-cycle fill.
- **Backpressure:** with `m_ready` low, reads continue until `occ + inflight` reaches 3. The FIFO then retains the remaining data, and none is lost.
- **Ordering:** stream order equals FIFO read order across pointer wrap-around.
- **Outputs:** all outputs except `fifo_rd_en` are registered or are pure decodes of registers.

## Test plan
1. **Basic fill and stream:** reset, write 0x11,0x22,0x33 into the FIFO, `drain_en` = 1, `m_ready` = 1.
   - `fifo_rd_en` is high for 3 cycles.
   - `m_data` is 0x11,0x22,0x33 on consecutive cycles, starting 2 cycles after the first read.
   - `xfer_cnt` ends at 3.
2. **Backpressure:** FIFO holds 10 words, `m_ready` = 0.
   - Exactly 3 reads are issued, `buf_occ` = 3, the FIFO holds 7, and `m_data` is stable at word 0.
   - Then `m_ready` = 1: all 10 words come out in order with no gap once reading resumes.
3. **Random ready, wrap-around:** 200 random bytes with `m_ready` random at 50%.
   - Output order matches input.
   - `fifo_rd_en` is never high with `fifo_empty` high.
   - `buf_occ` never exceeds 3.
4. **`drain_en` gating:** drop `drain_en` in the cycle after a read.
   - The inflight word is still captured and emitted.
   - No further `fifo_rd_en` until `drain_en` returns high.
5. **Reset mid-operation:** assert `rst_n` = 0 for 1 cycle with `buf_occ` = 2 and `inflight` = 1.
   - Next cycle `m_valid` = 0, `buf_occ` = 0, `xfer_cnt` = 0.
   - No stale word appears afterward.
6. **Counter wrap:** `CNT_W` = 4, run 17 transfers → `xfer_cnt` = 1.

Source files
------------

// File: rtl/fifo_stream_drain.sv
// Read-side drain stage for a synchronous FIFO with one-cycle registered read data.
// Issues FIFO reads, absorbs the read latency in a 3-entry buffer and presents
// words on a valid/ready stream at up to one word per clock.
module fifo_stream_drain #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              drain_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data_out,
  output logic              fifo_rd_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [1:0]        buf_occ,
  output logic [CNT_W-1:0]  xfer_cnt
);

  localparam int unsigned DEPTH = 3;
  localparam int unsigned PTR_W = 2;

  logic [DATA_W-1:0] buf_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [1:0]        occ;
  logic              inflight;
  logic              cap;
  logic              pop;

  // Pointers count 0,1,2,0 around the 3-entry buffer.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
  endfunction

  // Read only when a slot is reserved for every word in flight; independent of m_ready.
  assign fifo_rd_en = rst_n && drain_en && !fifo_empty &&
                      ((3'(occ) + 3'(inflight)) < 3'(DEPTH));

  assign cap     = inflight;
  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && m_ready;
  assign m_data  = buf_mem[rd_ptr];
  assign buf_occ = occ;

  // Buffer storage, pointers, occupancy and transfer counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      inflight   <= 1'b0;
      xfer_cnt   <= '0;
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      buf_mem[2] <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (cap) begin
        buf_mem[wr_ptr] <= fifo_data_out;
        wr_ptr          <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr   <= ptr_next(rd_ptr);
        xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
      case ({cap, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: behavioural FIFO model, scoreboard monitor and directed tests.
module tb_fifo_stream_drain;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        drain_en = 1'b0;
  logic        m_ready = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data_out = 8'h00;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;

  logic        fifo_rd_en, fifo_rd_en4;
  logic        m_valid, m_valid4;
  logic [7:0]  m_data, m_data4;
  logic [1:0]  buf_occ, buf_occ4;
  logic [15:0] xfer_cnt;
  logic [3:0]  xfer_cnt4;

  int          checks = 0;
  int          errors = 0;
  int          rd_count = 0;
  logic [15:0] sb_xfer = 16'd0;
  logic        rd_s = 1'b0;
  logic        hold_p = 1'b0;
  logic [7:0]  data_p = 8'h00;
  logic [7:0]  fifo_q [$];
  logic [7:0]  exp_q [$];

  logic        t1_rd [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        t1_v  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [7:0]  t1_d  [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};

  always #5 clk = ~clk;

  fifo_stream_drain #(.DATA_W(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .drain_en(drain_en), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .buf_occ(buf_occ), .xfer_cnt(xfer_cnt)
  );

  fifo_stream_drain #(.DATA_W(8), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .drain_en(drain_en), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out), .fifo_rd_en(fifo_rd_en4), .m_valid(m_valid4),
    .m_ready(m_ready), .m_data(m_data4), .buf_occ(buf_occ4), .xfer_cnt(xfer_cnt4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Synchronous FIFO model: registered read data and registered empty flag.
  always @(posedge clk) begin
    if (!rst_n) begin
      fifo_q.delete();
      fifo_empty    <= 1'b1;
      fifo_data_out <= 8'h00;
    end else begin
      if (rd_s && fifo_q.size() > 0) fifo_data_out <= fifo_q.pop_front();
      else                           fifo_data_out <= 8'($urandom);
      if (wr_en) fifo_q.push_back(wr_data);
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Monitor: scoreboard pop on handshake, counter model and stream invariants.
  always @(negedge clk) begin
    rd_s = fifo_rd_en;
    chk("xfer_cnt", 32'(xfer_cnt), 32'(sb_xfer));
    chk("xfer_cnt4", 32'(xfer_cnt4), 32'(sb_xfer[3:0]));
    chk("valid_vs_occ", 32'(m_valid), 32'(buf_occ != 2'd0));
    chk("rd_when_empty", 32'(fifo_rd_en && fifo_empty), 32'd0);
    chk("dut4_data", 32'({m_valid4, m_data4}), 32'({m_valid, m_data}));
    if (!rst_n) chk("rd_in_reset", 32'(fifo_rd_en), 32'd0);
    if (hold_p) chk("hold_stable", 32'({m_valid, m_data}), 32'({1'b1, data_p}));
    if (rst_n && fifo_rd_en) rd_count++;
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stale_word actual=%0h required=none", m_data);
      end else begin
        chk("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
      sb_xfer = sb_xfer + 16'd1;
    end
    if (!rst_n) sb_xfer = 16'd0;
    hold_p = rst_n && m_valid && !m_ready;
    data_p = m_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic fifo_write(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || m_valid !== 1'b0) && n < 1000) begin
      tick();
      n++;
    end
    chk(name, 32'(n < 1000), 32'd1);
  endtask

  initial begin
    int rc0;
    // Reset values.
    @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_buf_occ", 32'(buf_occ), 32'd0);
    chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    tick();
    rst_n = 1'b1;

    // Basic fill and stream with exact cycle timing.
    m_ready = 1'b1;
    fifo_write(8'h11);
    fifo_write(8'h22);
    fifo_write(8'h33);
    drain_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("t1_rd%0d", i), 32'(fifo_rd_en), 32'(t1_rd[i]));
      chk($sformatf("t1_v%0d", i), 32'(m_valid), 32'(t1_v[i]));
      if (t1_v[i]) chk($sformatf("t1_d%0d", i), 32'(m_data), 32'(t1_d[i]));
      tick();
    end
    chk("t1_xfer", 32'(xfer_cnt), 32'd3);

    // Backpressure: three reads, then a gapless burst of ten.
    do_reset();
    m_ready  = 1'b0;
    drain_en = 1'b0;
    for (int i = 0; i < 10; i++) fifo_write(8'hA0 + 8'(i));
    drain_en = 1'b1;
    rc0 = rd_count;
    repeat (6) tick();
    @(negedge clk);
    chk("t2_reads", 32'(rd_count - rc0), 32'd3);
    chk("t2_occ", 32'(buf_occ), 32'd3);
    chk("t2_fifo_left", 32'(fifo_q.size()), 32'd7);
    chk("t2_data0", 32'({m_valid, m_data}), 32'({1'b1, 8'hA0}));
    tick();
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("t2_burst%0d", i), 32'({m_valid, m_data}), 32'({1'b1, 8'hA0 + 8'(i)}));
      tick();
    end
    @(negedge clk);
    chk("t2_end_valid", 32'(m_valid), 32'd0);
    tick();

    // Random ready with pointer wrap-around.
    do_reset();
    drain_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      fifo_write(8'($urandom));
    end
    m_ready = 1'b1;
    wait_drain("t3_drain");
    chk("t3_xfer", 32'(xfer_cnt), 32'd200);

    // drain_en gating right after a read.
    do_reset();
    drain_en = 1'b0;
    m_ready  = 1'b1;
    for (int i = 0; i < 5; i++) fifo_write(8'h50 + 8'(i));
    drain_en = 1'b1;
    @(negedge clk);
    chk("t4_rd_first", 32'(fifo_rd_en), 32'd1);
    tick();
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t4_no_rd%0d", i), 32'(fifo_rd_en), 32'd0);
      chk($sformatf("t4_v%0d", i), 32'({m_valid, m_valid ? m_data : 8'h00}),
          (i == 1) ? 32'({1'b1, 8'h50}) : 32'd0);
      tick();
    end
    drain_en = 1'b1;
    wait_drain("t4_drain");
    chk("t4_xfer", 32'(xfer_cnt), 32'd5);

    // Reset with two words buffered and one in flight.
    m_ready  = 1'b0;
    drain_en = 1'b0;
    for (int i = 0; i < 5; i++) fifo_write(8'h60 + 8'(i));
    drain_en = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t5_pre_occ", 32'(buf_occ), 32'd2);
    chk("t5_pre_data", 32'(m_data), 32'h60);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_valid", 32'(m_valid), 32'd0);
    chk("t5_occ", 32'(buf_occ), 32'd0);
    chk("t5_xfer", 32'(xfer_cnt), 32'd0);
    tick();
    m_ready = 1'b1;
    fifo_write(8'h71);
    fifo_write(8'h72);
    wait_drain("t5_drain");
    chk("t5_xfer_after", 32'(xfer_cnt), 32'd2);

    // Counter wrap on the 4-bit instance.
    do_reset();
    drain_en = 1'b1;
    m_ready  = 1'b1;
    for (int i = 0; i < 17; i++) fifo_write(8'hC0 + 8'(i));
    wait_drain("t6_drain");
    chk("t6_xfer4", 32'(xfer_cnt4), 32'd1);
    chk("t6_xfer16", 32'(xfer_cnt), 32'd17);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
